cash_accumulator: RTL
=====================

CASH_ACCUMULATOR -- requirements
Module: cash_accumulator

Interface
REQ-001 Parameter VW, default 10, note-value width in bits (matches cash_inserted width).
REQ-002 Parameter AW, default 14, bill/accumulator width in bits.
REQ-003 Parameter TIMEOUT_CYC, default 1000, inactivity limit in clk cycles (used only when CASH_ACC_TIMEOUT_EN is defined).
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 bill_load  input  1  one-cycle pulse; starts a payment session.
REQ-007 bill_amount  input  AW  amount due, sampled on bill_load.
REQ-008 note_valid  input  1  one-cycle pulse from the note validator.
REQ-009 note_value  input  VW  denomination, sampled when note_valid=1.
REQ-010 cancel  input  1  user abort request, level-sampled.
REQ-011 note_accept  output  1  one-cycle pulse, note added to total.
REQ-012 note_reject  output  1  one-cycle pulse, note returned to user.
REQ-013 paid_total  output  AW  running accumulated amount.
REQ-014 change_due  output  AW  paid_total minus bill, valid while pay_done=1.
REQ-015 pay_done  output  1  one-cycle pulse; bill fully paid, feeds payment-complete input of top-level.
REQ-016 refund_req  output  1  one-cycle pulse; return paid_total to user.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, COLLECT, DONE and REFUND, registered, with one transition per clock at most.
REQ-019 IDLE: bill_load=1 with bill_amount!=0 SHALL latch bill_amount, clear paid_total, and enter COLLECT on the next edge; bill_load with bill_amount=0 SHALL be ignored.
REQ-020 Legal denominations SHALL be 10, 20, 50, 100, 200 and 500; any other note_value SHALL assert note_reject one cycle after note_valid.
REQ-021 COLLECT: a legal note SHALL assert note_accept one cycle after note_valid, with paid_total updated on the same edge.
REQ-022 A legal note whose addition would exceed 2^AW-1 SHALL be rejected, and paid_total SHALL remain unchanged.
REQ-023 When paid_total >= the latched bill after an accepted note, the FSM SHALL enter DONE on the next edge.
REQ-024 DONE SHALL last exactly one cycle, with pay_done=1 and change_due=paid_total-bill; the FSM then returns to IDLE.
REQ-025 On return to IDLE, paid_total and change_due SHALL hold their values until the next bill_load.
REQ-026 COLLECT with cancel=1 SHALL enter REFUND; in REFUND, refund_req=1 for one cycle, the FSM returns to IDLE, and paid_total is held for the refund amount.
REQ-027 If cancel and note_valid occur in the same COLLECT cycle, cancel SHALL win: the note is rejected and the FSM enters REFUND.
REQ-028 A note_valid outside COLLECT SHALL produce note_reject.
REQ-029 A bill_load outside IDLE SHALL be ignored.
REQ-030 note_accept and note_reject SHALL never be high in the same cycle.

Reset
REQ-031 Asserting reset SHALL, asynchronously, force IDLE and drive all outputs and the latched bill to 0.
REQ-032 Reset mid-session SHALL discard the session with no refund_req pulse.
REQ-033 After reset is released, the first bill_load SHALL be honoured on the first rising edge.

Configuration
REQ-034 With macro CASH_ACC_TIMEOUT_EN defined, a counter SHALL count COLLECT cycles without note_valid and clear on each note_valid.
REQ-035 When that counter reaches TIMEOUT_CYC, the FSM SHALL enter REFUND exactly as if cancel were asserted.
REQ-036 With CASH_ACC_TIMEOUT_EN undefined, no timeout logic SHALL exist, and COLLECT SHALL persist until payment completes, cancel, or reset.

Verification
REQ-037 Exact pay: bill 100, one note 100 -> note_accept, pay_done 1 cycle, change_due=0, paid_total=100.
REQ-038 Overpay with change: bill 120, notes 100 and 50 -> two note_accept pulses, pay_done, change_due=30.
REQ-039 Illegal note: bill 100, note_value 30 -> note_reject, paid_total stays 0, state stays COLLECT.
REQ-040 Cancel: bill 500, note 200, then cancel -> refund_req 1 cycle, paid_total=200, busy drops; cancel coincident with a note -> note_reject.
REQ-041 Reset mid-session: bill 300, note 100, then reset -> all outputs 0, no refund_req; a new bill 50 after reset completes normally.
REQ-042 Timeout (macro defined, TIMEOUT_CYC=20): bill 100, no notes for 20 cycles -> refund_req with paid_total=0; with the macro undefined, the FSM is still in COLLECT after 100 cycles.

Source files
------------

// File: rtl/cash_accumulator.sv
// cash_accumulator: payment-session FSM that totals validated notes against a latched bill.
// Define CASH_ACC_TIMEOUT_EN to add an inactivity timeout that refunds an abandoned session.
module cash_accumulator #(
  parameter int VW          = 10,
  parameter int AW          = 14,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bill_load,
  input  logic [AW-1:0] bill_amount,
  input  logic          note_valid,
  input  logic [VW-1:0] note_value,
  input  logic          cancel,
  output logic          note_accept,
  output logic          note_reject,
  output logic [AW-1:0] paid_total,
  output logic [AW-1:0] change_due,
  output logic          pay_done,
  output logic          refund_req,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE,
    REFUND
  } state_t;

  state_t        state_q;
  logic [AW-1:0] bill_q;
  logic [AW-1:0] paidTotal_q;
  logic [AW-1:0] changeDue_q;
  logic          noteAccept_q;
  logic          noteReject_q;
  logic          payDone_q;
  logic          refundReq_q;

  logic [AW:0]   noteSum;
  logic          noteOk;
  logic          timeoutHit;
  logic          abortReq;

  function automatic logic isLegal(input logic [VW-1:0] v);
    return (v == VW'(10))  || (v == VW'(20))  || (v == VW'(50)) ||
           (v == VW'(100)) || (v == VW'(200)) || (v == VW'(500));
  endfunction

  // One extra bit on the sum exposes overflow of the accumulator width.
  assign noteSum  = {1'b0, paidTotal_q} + (AW+1)'(note_value);
  assign noteOk   = isLegal(note_value) && !noteSum[AW];
  assign abortReq = cancel || timeoutHit;

`ifdef CASH_ACC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] idleCnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idleCnt_q <= '0;
    end else if (state_q != COLLECT || note_valid) begin
      idleCnt_q <= '0;
    end else if (idleCnt_q != CW'(TIMEOUT_CYC)) begin
      idleCnt_q <= idleCnt_q + CW'(1);
    end
  end

  assign timeoutHit = (state_q == COLLECT) && (idleCnt_q == CW'(TIMEOUT_CYC));
`else
  assign timeoutHit = 1'b0;
  if (TIMEOUT_CYC < 1) begin : gBadTimeout
  end
`endif

  // Pulse outputs default low each cycle; a completed payment outranks a late cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bill_q       <= '0;
      paidTotal_q  <= '0;
      changeDue_q  <= '0;
      noteAccept_q <= 1'b0;
      noteReject_q <= 1'b0;
      payDone_q    <= 1'b0;
      refundReq_q  <= 1'b0;
    end else begin
      noteAccept_q <= 1'b0;
      noteReject_q <= 1'b0;
      payDone_q    <= 1'b0;
      refundReq_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          noteReject_q <= note_valid;
          if (bill_load && bill_amount != '0) begin
            bill_q      <= bill_amount;
            paidTotal_q <= '0;
            changeDue_q <= '0;
            state_q     <= COLLECT;
          end
        end
        COLLECT: begin
          if (paidTotal_q >= bill_q) begin
            state_q      <= DONE;
            payDone_q    <= 1'b1;
            changeDue_q  <= paidTotal_q - bill_q;
            noteReject_q <= note_valid;
          end else if (abortReq) begin
            state_q      <= REFUND;
            refundReq_q  <= 1'b1;
            noteReject_q <= note_valid;
          end else if (note_valid) begin
            if (noteOk) begin
              noteAccept_q <= 1'b1;
              paidTotal_q  <= noteSum[AW-1:0];
            end else begin
              noteReject_q <= 1'b1;
            end
          end
        end
        DONE: begin
          noteReject_q <= note_valid;
          state_q      <= IDLE;
        end
        REFUND: begin
          noteReject_q <= note_valid;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_accept = noteAccept_q;
  assign note_reject = noteReject_q;
  assign paid_total  = paidTotal_q;
  assign change_due  = changeDue_q;
  assign pay_done    = payDone_q;
  assign refund_req  = refundReq_q;
  assign busy        = (state_q != IDLE);

endmodule
